// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a circular byte FIFO with sticky error flags and level IRQ.
module uart_rx_fifo #(
  parameter int P_CLK_FREQ   = 100_000_000,
  parameter int P_BAUD       = 115200,
  parameter int P_DEPTH_LOG2 = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_uart_rx,
  input  logic                    i_rx_pop,
  input  logic                    i_clr_err,
  input  logic                    i_irq_en,
  output logic [7:0]              o_rx_data,
  output logic                    o_rx_valid,
  output logic [P_DEPTH_LOG2:0]   o_level,
  output logic                    o_frame_err,
  output logic                    o_overrun,
  output logic                    o_irq_req
);
  localparam int BIT  = (P_CLK_FREQ + P_BAUD / 2) / P_BAUD;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);
  localparam int DL   = P_DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic rx_m, rx_s;
  logic [7:0] mem [2**DL];
  logic [DL-1:0] rd, wr;
  logic [DL:0] lvl, lvl_n;
  logic smp, push, pop, full, wr_en;
  always_comb begin
    smp   = (st == STOP) && (cnt == CW'(BIT - 1));
    push  = smp & rx_s;
    pop   = i_rx_pop & (lvl != '0);
    full  = lvl == (DL + 1)'(2**DL);
    wr_en = push & (~full | pop);
    lvl_n = lvl + (DL + 1)'(wr_en) - (DL + 1)'(pop);
  end
  assign o_rx_valid = lvl != '0;
  assign o_rx_data  = o_rx_valid ? mem[rd] : 8'h00;
  assign o_level    = lvl;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st   <= IDLE;
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
      cnt  <= cnt + CW'(1);
      case (st)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) st <= START;
        end
        START: if (cnt == CW'(HALF - 1)) begin
          cnt <= '0;
          idx <= '0;
          st  <= rx_s ? IDLE : DATA;
        end
        DATA: if (cnt == CW'(BIT - 1)) begin
          sh  <= {rx_s, sh[7:1]};
          cnt <= '0;
          idx <= idx + 3'd1;
          if (idx == 3'd7) st <= STOP;
        end
        default: if (smp) begin
          cnt <= '0;
          st  <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd          <= '0;
      wr          <= '0;
      lvl         <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_irq_req   <= 1'b0;
    end else begin
      if (wr_en) wr <= wr + DL'(1);
      if (pop) rd <= rd + DL'(1);
      lvl         <= lvl_n;
      o_frame_err <= (smp & ~rx_s) | (o_frame_err & ~i_clr_err);
      o_overrun   <= (push & full & ~pop) | (o_overrun & ~i_clr_err);
      o_irq_req   <= i_irq_en & (lvl_n != '0);
    end
  end
  always_ff @(posedge i_clk) if (wr_en) mem[wr] <= sh;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenario bench for uart_rx_fifo at a 50-clock bit period.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic pop = 1'b0;
  logic clr = 1'b0;
  logic irq_en = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [3:0] level;
  logic frame_err, overrun, irq_req;
  int errors = 0;
  int checks = 0;
  uart_rx_fifo #(.P_CLK_FREQ(100_000_000), .P_BAUD(2_000_000), .P_DEPTH_LOG2(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .i_rx_pop(pop), .i_clr_err(clr),
    .i_irq_en(irq_en), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_level(level),
    .o_frame_err(frame_err), .o_overrun(overrun), .o_irq_req(irq_req)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic v, input int n);
    @(posedge clk);
    #1 rx = v;
    repeat (n - 1) @(posedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stp, input int stop_len);
    drive(1'b0, 50);
    for (int i = 0; i < 8; i++) drive(b[i], 50);
    drive(stp, stop_len);
    if (!stp) drive(1'b1, 1);
  endtask
  task automatic pop_byte(output logic [7:0] d);
    @(posedge clk);
    #1 pop = 1'b1;
    d = rx_data;
    @(posedge clk);
    #1 pop = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", overrun); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq_req); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask
  task automatic test_basic;
    int n;
    logic [7:0] d;
    irq_en = 1'b1;
    n = 0;
    fork
      send_frame(8'h5A, 1'b1, 50);
      begin
        @(posedge clk);
        #1;
        while (!rx_valid && n < 600) begin
          @(negedge clk);
          n++;
        end
      end
    join
    checks++; if (n > 479) begin errors++; $display("FAIL basic_latency got %0d want <=479 cycles", n); end
    @(negedge clk);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL basic_data got %h want 5a", rx_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL basic_level got %0d want 1", level); end
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL basic_irq got %b want 1", irq_req); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b want 0", frame_err); end
    pop_byte(d);
    @(negedge clk);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL basic_pop_level got %0d want 0", level); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_pop_irq got %b want 0", irq_req); end
  endtask
  task automatic test_overrun;
    logic [7:0] d;
    irq_en = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 50);
    @(negedge clk);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovr_level got %0d want 8", level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ovr_irq_off got %b want 0", irq_req); end
    for (int i = 1; i <= 8; i++) begin
      pop_byte(d);
      checks++; if (d !== 8'(i)) begin errors++; $display("FAIL ovr_pop%0d got %h want %h", i, d, 8'(i)); end
    end
    @(negedge clk);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL ovr_drain got %0d want 0", level); end
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", overrun); end
  endtask
  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 50);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", frame_err); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL ferr_level got %0d want 0", level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ferr_ovr got %b want 0", overrun); end
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %b want 0", frame_err); end
  endtask
  task automatic test_glitch;
    logic [7:0] d;
    drive(1'b0, 10);
    drive(1'b1, 100);
    @(negedge clk);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL glitch_level got %0d want 0", level); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL glitch_flags got %b%b want 00", frame_err, overrun); end
    send_frame(8'h81, 1'b1, 50);
    @(negedge clk);
    checks++; if (rx_data !== 8'h81 || level !== 4'd1) begin errors++; $display("FAIL glitch_after got %h/%0d want 81/1", rx_data, level); end
    pop_byte(d);
  endtask
  task automatic test_push_pop;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 50);
    fork
      send_frame(8'h18, 1'b1, 50);
      begin
        repeat (478) @(posedge clk);
        #1 pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL pp_full_level got %0d want 8", level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pp_full_ovr got %b want 0", overrun); end
    for (int i = 1; i <= 8; i++) begin
      pop_byte(d);
      checks++; if (d !== 8'h10 + 8'(i)) begin errors++; $display("FAIL pp_pop%0d got %h want %h", i, d, 8'h10 + 8'(i)); end
    end
    pop_byte(d);
    @(negedge clk);
    checks++; if (level !== 4'd0 || rx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty_pop got %0d/%b want 0/0", level, rx_valid); end
    fork
      send_frame(8'h42, 1'b1, 50);
      begin
        repeat (478) @(posedge clk);
        #1 pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (level !== 4'd1 || rx_data !== 8'h42) begin errors++; $display("FAIL pp_empty_push got %0d/%h want 1/42", level, rx_data); end
    pop_byte(d);
  endtask
  task automatic test_back_to_back;
    logic [7:0] d;
    send_frame(8'hC3, 1'b1, 35);
    send_frame(8'h3C, 1'b1, 50);
    @(negedge clk);
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL b2b_level got %0d want 2", level); end
    pop_byte(d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL b2b_first got %h want c3", d); end
    pop_byte(d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h want 3c", d); end
  endtask
  task automatic test_reset_midframe;
    logic [7:0] d;
    send_frame(8'h11, 1'b1, 50);
    fork
      send_frame(8'hFF, 1'b1, 50);
      begin
        repeat (200) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", level); end
    send_frame(8'hA5, 1'b1, 50);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL midrst_count got %0d want 1", level); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL midrst_data got %h want a5", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b want 0", frame_err); end
    pop_byte(d);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_push_pop;
    test_back_to_back;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
